mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives register-file, memory, PC and ALU controls. For R-type instructions it decodes funct[5:0] into the 3-bit ALU select bus. It sits between the instruction register and the datapath and replaces hard-wired single-cycle control.

Parameters:
MEM_WAIT_MAX, 15, max memory wait cycles before the timeout error (4-bit counter)
ILLEGAL_TRAP, 1, 1 = halt in TRAP on an illegal opcode/funct; 0 = treat it as a NOP

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
instr  in  32  instruction register contents (opcode [31:26], funct [5:0])
mem_ready  in  1  memory completes the current access this cycle
alu_zero  in  1  ALU zero flag, used by beq
ir_write  out  1  load the instruction register
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update if alu_zero
pc_src  out  1  0 = PC+4, 1 = branch target
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  writeback data from memory
reg_write  out  1  register-file write enable
reg_dst  out  1  1 = rd, 0 = rt
alu_src_b  out  2  00 = reg, 01 = const 4, 10 = sign-extended immediate
select_bits_ALU  out  3  ALU operation select
state  out  3  current FSM state, for debug
error  out  1  sticky: illegal instruction or memory timeout

Behaviour:
- Reset (synchronous, active-high): state = FETCH, all enables 0, select_bits_ALU = ALU_ADD, error = 0, wait counter = 0.
- Reset asserted mid-operation wins over every transition. Any pending mem_read or mem_write drops on the next edge.
- FETCH: mem_read = 1, alu_src_b = 01, select = ADD.
  - Hold FETCH until mem_ready.
  - On mem_ready: ir_write = 1 and pc_write = 1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no enables asserted.
  - R-type (opcode 000000) goes to EXEC_R.
  - lw (100011) and sw (101011) go to EXEC_MEM.
  - beq (000100) goes to EXEC_BR.
  - addi (001000) goes to EXEC_I.
  - Any other opcode goes to TRAP when ILLEGAL_TRAP = 1, else to FETCH.
- EXEC_R: alu_src_b = 00, select_bits_ALU from the funct decode. Next state is WB_R.
  - Supported funct: add, addu, sub, subu, and, or, nor, sltu, sll, srl.
  - An unsupported funct is illegal and follows the same ILLEGAL_TRAP rule as an illegal opcode.
- WB_R: reg_write = 1, reg_dst = 1; then FETCH.
- EXEC_I: alu_src_b = 10, select = ADD; then WB_I.
- WB_I: reg_write = 1, reg_dst = 0; then FETCH.
- EXEC_MEM: address calculation, alu_src_b = 10, select = ADD; then MEM.
- MEM: mem_read = 1 for lw, mem_write = 1 for sw. Hold until mem_ready.
  - lw goes to WB_MEM; sw goes to FETCH.
- WB_MEM: reg_write = 1, mem_to_reg = 1, reg_dst = 0; then FETCH.
- EXEC_BR: select = SUB, alu_src_b = 00, pc_write_cond = 1, pc_src = 1; then FETCH.
- Memory wait counter:
  - Counts consecutive cycles in FETCH or MEM without mem_ready.
  - If it reaches MEM_WAIT_MAX: error = 1, go to TRAP.
  - Counter clears when mem_ready arrives or the state changes.
- mem_ready arriving in the same cycle the counter reaches MEM_WAIT_MAX counts as success.
- TRAP: all enables 0, error held, state frozen until reset.
- Latencies with zero-wait memory: R-type 4 cycles, addi 4, beq 3, sw 4, lw 5.
- Every control output is a registered Moore decode of state plus the latched opcode/funct. No output combinationally depends on mem_ready, except ir_write/pc_write in FETCH, which are qualified by mem_ready.
- The 3-bit state encoding is only a debug view. The FSM has 11 states (FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, EXEC_MEM, MEM, WB_MEM, EXEC_BR, TRAP), so the `state` port shows a fixed 3-bit folding of the internal state. The 3-bit folding is defined in mips_ctrl_pkg.

Optional Feature:
- Macro: MIPS_CTRL_PERF_COUNT_EN.
- With the macro defined: extra output retired_count [31:0], wrapping.
  - Increments on each transition into FETCH from WB_R, WB_I, WB_MEM, EXEC_BR or MEM (sw).
  - Reset value 0. Does not count NOP-treated illegal instructions.
- Without the macro: the port is absent and no counter logic is built.

Decomposition:
- mips_ctrl_pkg holds:
  - state encoding localparams
  - opcode constants (RTYPE, LW, SW, BEQ, ADDI)
  - funct constants (ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, NOR 100111, SLTU 101011, SLL 000000, SRL 000010)
  - ALU select constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL
- One sub-module, alu_funct_decode: combinational, funct[5:0] -> select_bits_ALU[2:0] plus an illegal flag. It is instantiated by the FSM and reused by the existing ALU control testbench.

Test Plan:
- Reset held 3 cycles, then released with mem_ready = 1 and instr = add: state FETCH, all enables 0, select = ALU_ADD, error = 0. Then cycle 1 asserts ir_write and pc_write.
- R-type sequence with zero-wait memory: add, sub, nor, sltu, srl, each taking 4 cycles. select_bits_ALU in EXEC_R matches the package constant for each funct. reg_write and reg_dst pulse 1 in WB_R.
- lw with mem_ready low for 3 cycles in MEM: mem_read held 4 cycles, then WB_MEM with reg_write = 1 and mem_to_reg = 1. Total 8 cycles.
- beq with alu_zero = 1: EXEC_BR shows pc_write_cond = 1, pc_src = 1, select = ALU_SUB; back to FETCH after 3 cycles.
- Illegal cases:
  - opcode 111111 with ILLEGAL_TRAP = 1: TRAP, error = 1, held until reset.
  - funct 000011 with ILLEGAL_TRAP = 0: back to FETCH, error = 0.
- mem_ready stuck low in FETCH: after 15 cycles error = 1 and state = TRAP. A mid-trap reset returns to FETCH with error = 0. With MIPS_CTRL_PERF_COUNT_EN, retired_count = 0 after the reset.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS multi-cycle controller: FSM states,
// their 3-bit debug folding, opcode/funct encodings and ALU select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_EXEC_MEM, S_MEM, S_WB_MEM, S_EXEC_BR, S_TRAP
    } state_e;

    // Debug view: the four EXEC states share one code, as do the three WB states.
    localparam logic [2:0] DBG_FETCH  = 3'd0;
    localparam logic [2:0] DBG_DECODE = 3'd1;
    localparam logic [2:0] DBG_EXEC   = 3'd2;
    localparam logic [2:0] DBG_MEM    = 3'd3;
    localparam logic [2:0] DBG_WB     = 3'd4;
    localparam logic [2:0] DBG_TRAP   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       pc_write_cond;
        logic       pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
        reg_dst: 1'b0, pc_write_cond: 1'b0, pc_src: 1'b0,
        alu_src_b: 2'b00, alu_sel: ALU_ADD
    };

    function automatic logic [2:0] fold_state(input state_e s);
        case (s)
            S_FETCH:                                  return DBG_FETCH;
            S_DECODE:                                 return DBG_DECODE;
            S_EXEC_R, S_EXEC_I, S_EXEC_MEM, S_EXEC_BR: return DBG_EXEC;
            S_MEM:                                    return DBG_MEM;
            S_WB_R, S_WB_I, S_WB_MEM:                 return DBG_WB;
            default:                                  return DBG_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_funct_decode.sv
// R-type funct field to ALU select decoder; flags any funct the ALU cannot execute.
module alu_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] select_bits_ALU,
    output logic       illegal
);

    always_comb begin
        // NOTE: both outputs get a default before the case so no latch is inferred.
        select_bits_ALU = ALU_ADD;
        illegal         = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU: select_bits_ALU = ALU_ADD;
            FN_SUB, FN_SUBU: select_bits_ALU = ALU_SUB;
            FN_AND:          select_bits_ALU = ALU_AND;
            FN_OR:           select_bits_ALU = ALU_OR;
            FN_NOR:          select_bits_ALU = ALU_NOR;
            FN_SLTU:         select_bits_ALU = ALU_SLT;
            FN_SLL:          select_bits_ALU = ALU_SLL;
            FN_SRL:          select_bits_ALU = ALU_SRL;
            default:         illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with registered Moore outputs and a memory-wait timeout.
// Optional MIPS_CTRL_PERF_COUNT_EN adds a retired-instruction counter output.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        reg_dst,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  select_bits_ALU,
    output logic [2:0]  state,
    output logic        error
`ifdef MIPS_CTRL_PERF_COUNT_EN
    , output logic [31:0] retired_count
`endif
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

    state_e     cur_state, next_state;
    ctrl_t      ctrl_q, next_ctrl;
    logic [3:0] wait_cnt, next_wait_cnt;
    logic       is_sw_q, next_is_sw, next_error;
    logic [2:0] funct_sel;
    logic       funct_illegal;
    logic       req;

    wire [5:0] opcode = instr[31:26];

    // alu_zero is consumed by the datapath through pc_write_cond.
    logic unused_bits;
    assign unused_bits = ^{alu_zero, instr[25:6]};

    alu_funct_decode u_funct_decode (
        .funct           (instr[5:0]),
        .select_bits_ALU (funct_sel),
        .illegal         (funct_illegal)
    );

    // A request is only outstanding once the registered read/write strobe is up, so the
    // first FETCH cycle after reset is a bubble that raises mem_read.
    assign req = ctrl_q.mem_read | ctrl_q.mem_write;

    always_comb begin
        next_state    = cur_state;
        next_wait_cnt = '0;
        next_is_sw    = is_sw_q;
        next_error    = error;
        case (cur_state)
            S_FETCH, S_MEM: begin
                if (req && mem_ready) begin
                    if (cur_state == S_FETCH) next_state = S_DECODE;
                    else                      next_state = is_sw_q ? S_FETCH : S_WB_MEM;
                end else if (req && wait_cnt == WAIT_LAST) begin
                    next_state = S_TRAP;
                    next_error = 1'b1;
                end else if (req) begin
                    next_wait_cnt = wait_cnt + 4'd1;
                end
            end
            S_DECODE: begin
                next_is_sw = (opcode == OP_SW);
                case (opcode)
                    OP_RTYPE:     next_state = funct_illegal ? S_TRAP : S_EXEC_R;
                    OP_LW, OP_SW: next_state = S_EXEC_MEM;
                    OP_BEQ:       next_state = S_EXEC_BR;
                    OP_ADDI:      next_state = S_EXEC_I;
                    default:      next_state = S_TRAP;
                endcase
                if (next_state == S_TRAP) begin
                    if (ILLEGAL_TRAP) next_error = 1'b1;
                    else              next_state = S_FETCH;
                end
            end
            S_EXEC_R:   next_state = S_WB_R;
            S_EXEC_I:   next_state = S_WB_I;
            S_EXEC_MEM: next_state = S_MEM;
            S_WB_R, S_WB_I, S_WB_MEM, S_EXEC_BR: next_state = S_FETCH;
            default:    next_state = S_TRAP;
        endcase

        // Outputs are decoded from the state being entered so they register in step with it.
        next_ctrl = CTRL_IDLE;
        case (next_state)
            S_FETCH: begin
                next_ctrl.mem_read  = 1'b1;
                next_ctrl.alu_src_b = 2'b01;
            end
            S_EXEC_R: next_ctrl.alu_sel = funct_sel;
            S_WB_R: begin
                next_ctrl.reg_write = 1'b1;
                next_ctrl.reg_dst   = 1'b1;
            end
            S_EXEC_I, S_EXEC_MEM: next_ctrl.alu_src_b = 2'b10;
            S_WB_I: next_ctrl.reg_write = 1'b1;
            S_MEM: begin
                next_ctrl.mem_read  = ~next_is_sw;
                next_ctrl.mem_write = next_is_sw;
            end
            S_WB_MEM: begin
                next_ctrl.reg_write  = 1'b1;
                next_ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC_BR: begin
                next_ctrl.alu_sel       = ALU_SUB;
                next_ctrl.pc_write_cond = 1'b1;
                next_ctrl.pc_src        = 1'b1;
            end
            default: next_ctrl = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments; reset wins over any transition.
        if (reset) begin
            cur_state <= S_FETCH;
            ctrl_q    <= CTRL_IDLE;
            wait_cnt  <= '0;
            is_sw_q   <= 1'b0;
            error     <= 1'b0;
        end else begin
            cur_state <= next_state;
            ctrl_q    <= next_ctrl;
            wait_cnt  <= next_wait_cnt;
            is_sw_q   <= next_is_sw;
            error     <= next_error;
        end
    end

    assign ir_write        = (cur_state == S_FETCH) && ctrl_q.mem_read && mem_ready;
    assign pc_write        = ir_write;
    assign pc_write_cond   = ctrl_q.pc_write_cond;
    assign pc_src          = ctrl_q.pc_src;
    assign mem_read        = ctrl_q.mem_read;
    assign mem_write       = ctrl_q.mem_write;
    assign mem_to_reg      = ctrl_q.mem_to_reg;
    assign reg_write       = ctrl_q.reg_write;
    assign reg_dst         = ctrl_q.reg_dst;
    assign alu_src_b       = ctrl_q.alu_src_b;
    assign select_bits_ALU = ctrl_q.alu_sel;
    assign state           = fold_state(cur_state);

`ifdef MIPS_CTRL_PERF_COUNT_EN
    logic retire;
    assign retire = (next_state == S_FETCH) &&
                    (cur_state inside {S_WB_R, S_WB_I, S_WB_MEM, S_EXEC_BR, S_MEM});

    always_ff @(posedge clk) begin
        if (reset)       retired_count <= '0;
        else if (retire) retired_count <= retired_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: two instances differ only in ILLEGAL_TRAP.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b1;
    logic        alu_zero = 1'b0;

    logic ir_a, pcw_a, pwc_a, ps_a, mr_a, mw_a, m2r_a, rw_a, rd_a, err_a;
    logic ir_b, pcw_b, pwc_b, ps_b, mr_b, mw_b, m2r_b, rw_b, rd_b, err_b;
    logic [1:0] srcb_a, srcb_b;
    logic [2:0] sel_a, sel_b, st_a, st_b;
`ifdef MIPS_CTRL_PERF_COUNT_EN
    logic [31:0] retired_a, retired_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15), .ILLEGAL_TRAP(1'b1)) dut_a (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .ir_write(ir_a), .pc_write(pcw_a), .pc_write_cond(pwc_a), .pc_src(ps_a),
        .mem_read(mr_a), .mem_write(mw_a), .mem_to_reg(m2r_a), .reg_write(rw_a),
        .reg_dst(rd_a), .alu_src_b(srcb_a), .select_bits_ALU(sel_a), .state(st_a),
        .error(err_a)
`ifdef MIPS_CTRL_PERF_COUNT_EN
        , .retired_count(retired_a)
`endif
    );

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15), .ILLEGAL_TRAP(1'b0)) dut_b (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .ir_write(ir_b), .pc_write(pcw_b), .pc_write_cond(pwc_b), .pc_src(ps_b),
        .mem_read(mr_b), .mem_write(mw_b), .mem_to_reg(m2r_b), .reg_write(rw_b),
        .reg_dst(rd_b), .alu_src_b(srcb_b), .select_bits_ALU(sel_b), .state(st_b),
        .error(err_b)
`ifdef MIPS_CTRL_PERF_COUNT_EN
        , .retired_count(retired_b)
`endif
    );

    // {ir, pc, mem_read, mem_write, pc_write_cond, pc_src, mem_to_reg, reg_write, reg_dst,
    //  alu_src_b, select, state, error}
    wire [17:0] obs_a = {ir_a, pcw_a, mr_a, mw_a, pwc_a, ps_a, m2r_a, rw_a, rd_a,
                         srcb_a, sel_a, st_a, err_a};
    wire [17:0] obs_b = {ir_b, pcw_b, mr_b, mw_b, pwc_b, ps_b, m2r_b, rw_b, rd_b,
                         srcb_b, sel_b, st_b, err_b};

    localparam logic [17:0] V_IDLE       = {9'b000_000_000, 2'b00, ALU_ADD, 3'd0, 1'b0};
    localparam logic [17:0] V_FETCH      = {9'b111_000_000, 2'b01, ALU_ADD, 3'd0, 1'b0};
    localparam logic [17:0] V_FETCH_WAIT = {9'b001_000_000, 2'b01, ALU_ADD, 3'd0, 1'b0};
    localparam logic [17:0] V_DECODE     = {9'b000_000_000, 2'b00, ALU_ADD, 3'd1, 1'b0};
    localparam logic [17:0] V_EXEC_IMM   = {9'b000_000_000, 2'b10, ALU_ADD, 3'd2, 1'b0};
    localparam logic [17:0] V_WB_R       = {9'b000_000_011, 2'b00, ALU_ADD, 3'd4, 1'b0};
    localparam logic [17:0] V_WB_I       = {9'b000_000_010, 2'b00, ALU_ADD, 3'd4, 1'b0};
    localparam logic [17:0] V_MEM_RD     = {9'b001_000_000, 2'b00, ALU_ADD, 3'd3, 1'b0};
    localparam logic [17:0] V_MEM_WR     = {9'b000_100_000, 2'b00, ALU_ADD, 3'd3, 1'b0};
    localparam logic [17:0] V_WB_MEM     = {9'b000_000_110, 2'b00, ALU_ADD, 3'd4, 1'b0};
    localparam logic [17:0] V_EXEC_BR    = {9'b000_011_000, 2'b00, ALU_SUB, 3'd2, 1'b0};
    localparam logic [17:0] V_TRAP       = {9'b000_000_000, 2'b00, ALU_ADD, 3'd7, 1'b1};

    localparam logic [31:0] I_LW   = {6'b100011, 26'h0};
    localparam logic [31:0] I_SW   = {6'b101011, 26'h0};
    localparam logic [31:0] I_BEQ  = {6'b000100, 26'h0};
    localparam logic [31:0] I_ADDI = {6'b001000, 26'h0};
    localparam logic [31:0] I_BAD  = {6'b111111, 26'h0};

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        return {6'b000000, 20'h0, funct};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; instr = rtype(6'b100000);
        repeat (3) tick();
        checks++;
        if (obs_a !== V_IDLE) begin
            errors++; $display("FAIL reset_hold: got %h want %h", obs_a, V_IDLE);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs_a !== V_IDLE) begin
            errors++; $display("FAIL reset_release: got %h want %h", obs_a, V_IDLE);
        end
        tick();
        checks++;
        if ({ir_a, pcw_a} !== 2'b11) begin
            errors++; $display("FAIL first_fetch ir/pc: got %b want 11", {ir_a, pcw_a});
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  functs [5] = '{6'b100000, 6'b100010, 6'b100111, 6'b101011, 6'b000010};
        logic [2:0]  sels   [5] = '{ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT, ALU_SRL};
        logic [17:0] exp_v  [4];
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr = rtype(functs[k]);
            exp_v = '{V_FETCH, V_DECODE, {9'b0, 2'b00, sels[k], 3'd2, 1'b0}, V_WB_R};
            for (int c = 0; c < 4; c++) begin
                #1;
                checks++;
                if (obs_a !== exp_v[c]) begin
                    errors++;
                    $display("FAIL rtype funct=%b cyc%0d: got %h want %h", functs[k], c, obs_a, exp_v[c]);
                end
                tick();
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [17:0] exp_v [8] = '{V_FETCH, V_DECODE, V_EXEC_IMM, V_MEM_RD,
                                   V_MEM_RD, V_MEM_RD, V_MEM_RD, V_WB_MEM};
        logic        rdy   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        instr = I_LW;
        for (int c = 0; c < 8; c++) begin
            mem_ready = rdy[c];
            #1;
            checks++;
            if (obs_a !== exp_v[c]) begin
                errors++; $display("FAIL lw_wait cyc%0d: got %h want %h", c, obs_a, exp_v[c]);
            end
            tick();
        end
    endtask

    task automatic test_beq();
        logic [17:0] exp_v [3] = '{V_FETCH, V_DECODE, V_EXEC_BR};
        instr = I_BEQ; alu_zero = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (obs_a !== exp_v[c]) begin
                errors++; $display("FAIL beq cyc%0d: got %h want %h", c, obs_a, exp_v[c]);
            end
            tick();
        end
        alu_zero = 1'b0;
        checks++;
        if (obs_a !== V_FETCH) begin
            errors++; $display("FAIL beq_return: got %h want %h", obs_a, V_FETCH);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_v [8] = '{V_FETCH, V_DECODE, V_EXEC_IMM, V_WB_I,
                                   V_FETCH, V_DECODE, V_EXEC_IMM, V_MEM_WR};
        mem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            instr = (c < 4) ? I_ADDI : I_SW;
            #1;
            checks++;
            if (obs_a !== exp_v[c]) begin
                errors++; $display("FAIL addi_sw cyc%0d: got %h want %h", c, obs_a, exp_v[c]);
            end
            tick();
        end
        checks++;
        if (obs_a !== V_FETCH) begin
            errors++; $display("FAIL sw_return: got %h want %h", obs_a, V_FETCH);
        end
`ifdef MIPS_CTRL_PERF_COUNT_EN
        checks++;
        if (retired_a !== 32'd9) begin
            errors++; $display("FAIL retired_count: got %0d want 9", retired_a);
        end
`endif
    endtask

    task automatic test_illegal_opcode();
        logic rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        instr = I_BAD; mem_ready = 1'b1;
        #1;
        checks++;
        if (obs_a !== V_FETCH) begin
            errors++; $display("FAIL bad_op fetch: got %h want %h", obs_a, V_FETCH);
        end
        tick();
        checks++;
        if (obs_a !== V_DECODE) begin
            errors++; $display("FAIL bad_op decode: got %h want %h", obs_a, V_DECODE);
        end
        tick();
        checks++;
        if ({st_b, err_b} !== 4'b0000) begin
            errors++; $display("FAIL bad_op nop state/error: got %b want 0000", {st_b, err_b});
        end
        for (int c = 0; c < 4; c++) begin
            mem_ready = rdy[c];
            #1;
            checks++;
            if (obs_a !== V_TRAP) begin
                errors++; $display("FAIL bad_op trap cyc%0d: got %h want %h", c, obs_a, V_TRAP);
            end
            tick();
        end
    endtask

    task automatic test_illegal_funct();
        reset = 1'b1; mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        instr = rtype(6'b000011);
        #1;
        checks++;
        if (obs_b !== V_FETCH) begin
            errors++; $display("FAIL bad_funct fetch: got %h want %h", obs_b, V_FETCH);
        end
        tick();
        checks++;
        if (obs_b !== V_DECODE) begin
            errors++; $display("FAIL bad_funct decode: got %h want %h", obs_b, V_DECODE);
        end
        tick();
        checks++;
        if (obs_b !== V_FETCH) begin
            errors++; $display("FAIL bad_funct nop: got %h want %h", obs_b, V_FETCH);
        end
        checks++;
        if (obs_a !== V_TRAP) begin
            errors++; $display("FAIL bad_funct trap: got %h want %h", obs_a, V_TRAP);
        end
    endtask

    task automatic test_mem_timeout();
        reset = 1'b1; mem_ready = 1'b0; instr = rtype(6'b100000);
        tick();
        reset = 1'b0;
        tick();
        for (int c = 1; c <= 15; c++) begin
            checks++;
            if (obs_a !== V_FETCH_WAIT) begin
                errors++; $display("FAIL timeout wait%0d: got %h want %h", c, obs_a, V_FETCH_WAIT);
            end
            tick();
        end
        checks++;
        if (obs_a !== V_TRAP) begin
            errors++; $display("FAIL timeout trap: got %h want %h", obs_a, V_TRAP);
        end
        tick();
        checks++;
        if (obs_a !== V_TRAP) begin
            errors++; $display("FAIL timeout trap_hold: got %h want %h", obs_a, V_TRAP);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (obs_a !== V_IDLE) begin
            errors++; $display("FAIL trap_reset: got %h want %h", obs_a, V_IDLE);
        end
`ifdef MIPS_CTRL_PERF_COUNT_EN
        checks++;
        if (retired_a !== 32'd0) begin
            errors++; $display("FAIL trap_reset retired_count: got %0d want 0", retired_a);
        end
`endif
    endtask

    task automatic test_ready_at_limit();
        reset = 1'b1; mem_ready = 1'b0; instr = rtype(6'b100000);
        tick();
        reset = 1'b0;
        tick();
        repeat (14) tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs_a !== V_FETCH) begin
            errors++; $display("FAIL ready_at_limit fetch: got %h want %h", obs_a, V_FETCH);
        end
        tick();
        checks++;
        if (obs_a !== V_DECODE) begin
            errors++; $display("FAIL ready_at_limit decode: got %h want %h", obs_a, V_DECODE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_illegal_opcode();
        test_illegal_funct();
        test_mem_timeout();
        test_ready_at_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
